// File: rtl/a51_key_loader_if.sv
// ----------------------------------------------------------------------------
// a51_key_loader_if
//   Bundles the host request/status signals and the serial load signals of the
//   a51 keystream core into one interface for a51_key_loader.
//
//   Host side     : start, key_in, frame_in -> loader; busy, ready, err,
//                   ks_word, ks_valid <- loader
//   Core side     : startloading, keybit <- loader; doneloading, bitout -> loader
//
//   Modports
//     slave  : the loader itself (a51_key_loader)
//     master : the environment driving requests and modelling the core
// ----------------------------------------------------------------------------
interface a51_key_loader_if #(
   parameter int KEY_BITS   = 64,
   parameter int FRAME_BITS = 22,
   parameter int KS_BITS    = 32
);
   // Host request / status
   logic                  start;
   logic [KEY_BITS-1:0]   key_in;
   logic [FRAME_BITS-1:0] frame_in;
   logic                  busy;
   logic                  ready;
   logic                  err;
   logic [KS_BITS-1:0]    ks_word;
   logic                  ks_valid;

   // Serial load link to the keystream core
   logic                  startloading;
   logic                  keybit;
   logic                  doneloading;
   logic                  bitout;

   modport slave (
      input  start, key_in, frame_in, doneloading, bitout,
      output busy, ready, err, startloading, keybit, ks_word, ks_valid
   );

   modport master (
      output start, key_in, frame_in, doneloading, bitout,
      input  busy, ready, err, startloading, keybit, ks_word, ks_valid
   );
endinterface

// File: rtl/a51_key_loader.sv
// ----------------------------------------------------------------------------
// a51_key_loader
//   Sequencer in front of the a51 keystream core. Captures a parallel session
//   key and frame number, then drives the core's serial load port: one
//   startloading pulse, KEY_BITS key bits (key_in[0] first), FRAME_BITS frame
//   bits (frame_in[0] first). It then waits for doneloading and raises ready,
//   or flags err if the core does not answer within DONE_TIMEOUT cycles.
//
//   Ports
//     clk, rst : rising-edge clock, asynchronous active-high reset
//     bus      : a51_key_loader_if.slave
//                start/key_in/frame_in in; busy/ready/err out (host side)
//                startloading/keybit out; doneloading/bitout in (core side)
//                ks_word/ks_valid out (first keystream word)
//
//   Build option
//     A51_CAPTURE_EN : when defined, the first KS_BITS keystream bits after
//                      doneloading are shifted into ks_word (first bit ends in
//                      the MSB) and announced with a one-cycle ks_valid.
//                      When undefined, ks_word/ks_valid are tied to 0.
// ----------------------------------------------------------------------------
module a51_key_loader #(
   parameter int KEY_BITS     = 64,
   parameter int FRAME_BITS   = 22,
   parameter int KS_BITS      = 32,
   parameter int DONE_TIMEOUT = 511
) (
   input logic              clk,
   input logic              rst,
   a51_key_loader_if.slave  bus
);

   localparam int BIT_W = 7;
   localparam int TO_W  = $clog2(DONE_TIMEOUT + 1);

   localparam logic [BIT_W-1:0] KEY_LAST   = BIT_W'(KEY_BITS - 1);
   localparam logic [BIT_W-1:0] FRAME_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(DONE_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_KEY,
      S_FRAME,
      S_WAIT_DONE,
      S_READY
   } state_t;

   state_t                state_q,        state_d;
   logic [KEY_BITS-1:0]   key_sr_q,       key_sr_d;
   logic [FRAME_BITS-1:0] frame_sr_q,     frame_sr_d;
   logic [BIT_W-1:0]      bit_cnt_q,      bit_cnt_d;
   logic [TO_W-1:0]       to_cnt_q,       to_cnt_d;
   logic                  busy_q,         busy_d;
   logic                  ready_q,        ready_d;
   logic                  err_q,          err_d;
   logic                  startloading_q, startloading_d;
   logic                  keybit_q,       keybit_d;

   // ------------------------------------------------------------------------
   // Next-state / next-output logic. Outputs are computed one cycle ahead so
   // every output leaves the block straight from a flop and lines up with the
   // state it belongs to (e.g. keybit_q holds key bit 0 in the first KEY cycle).
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned below gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_d        = state_q;
      key_sr_d       = key_sr_q;
      frame_sr_d     = frame_sr_q;
      bit_cnt_d      = bit_cnt_q;
      to_cnt_d       = to_cnt_q;
      busy_d         = busy_q;
      ready_d        = ready_q;
      err_d          = 1'b0;
      startloading_d = 1'b0;
      keybit_d       = 1'b0;

      unique case (state_q)
         S_IDLE, S_READY: begin
            if (bus.start) begin
               key_sr_d       = bus.key_in;
               frame_sr_d     = bus.frame_in;
               bit_cnt_d      = '0;
               to_cnt_d       = '0;
               busy_d         = 1'b1;
               ready_d        = 1'b0;
               startloading_d = 1'b1;
               state_d        = S_START;
            end
         end

         S_START: begin
            keybit_d = key_sr_q[0];
            key_sr_d = key_sr_q >> 1;
            state_d  = S_KEY;
         end

         // bit_cnt_q is the index of the bit currently on keybit_q.
         S_KEY: begin
            if (bit_cnt_q == KEY_LAST) begin
               keybit_d   = frame_sr_q[0];
               frame_sr_d = frame_sr_q >> 1;
               bit_cnt_d  = '0;
               state_d    = S_FRAME;
            end else begin
               keybit_d  = key_sr_q[0];
               key_sr_d  = key_sr_q >> 1;
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end

         S_FRAME: begin
            if (bit_cnt_q == FRAME_LAST) begin
               bit_cnt_d = '0;
               to_cnt_d  = '0;
               state_d   = S_WAIT_DONE;
            end else begin
               keybit_d   = frame_sr_q[0];
               frame_sr_d = frame_sr_q >> 1;
               bit_cnt_d  = bit_cnt_q + 1'b1;
            end
         end

         // doneloading wins over a timeout expiring on the same edge.
         S_WAIT_DONE: begin
            if (bus.doneloading) begin
               busy_d  = 1'b0;
               ready_d = 1'b1;
               state_d = S_READY;
            end else if (to_cnt_q == TO_LAST) begin
               err_d    = 1'b1;
               busy_d   = 1'b0;
               to_cnt_d = '0;
               state_d  = S_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the shift registers and counters are reset along with the state so
   // an abandoned load leaves no stale key material or count behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         key_sr_q       <= '0;
         frame_sr_q     <= '0;
         bit_cnt_q      <= '0;
         to_cnt_q       <= '0;
         busy_q         <= 1'b0;
         ready_q        <= 1'b0;
         err_q          <= 1'b0;
         startloading_q <= 1'b0;
         keybit_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q        <= state_d;
         key_sr_q       <= key_sr_d;
         frame_sr_q     <= frame_sr_d;
         bit_cnt_q      <= bit_cnt_d;
         to_cnt_q       <= to_cnt_d;
         busy_q         <= busy_d;
         ready_q        <= ready_d;
         err_q          <= err_d;
         startloading_q <= startloading_d;
         keybit_q       <= keybit_d;
      end
   end

   assign bus.busy         = busy_q;
   assign bus.ready        = ready_q;
   assign bus.err          = err_q;
   assign bus.startloading = startloading_q;
   assign bus.keybit       = keybit_q;

`ifdef A51_CAPTURE_EN
   // ------------------------------------------------------------------------
   // Keystream capture: first sample on the WAIT_DONE->READY edge, then one
   // per cycle while READY. A new accepted start abandons a partial capture.
   // ------------------------------------------------------------------------
   localparam int CAP_W = $clog2(KS_BITS + 1);
   localparam logic [CAP_W-1:0] CAP_FULL = CAP_W'(KS_BITS);

   logic [KS_BITS-1:0] cap_sr_q,   cap_sr_d;
   logic [KS_BITS-1:0] ks_word_q,  ks_word_d;
   logic [CAP_W-1:0]   cap_cnt_q,  cap_cnt_d;
   logic               cap_act_q,  cap_act_d;
   logic               ks_valid_q, ks_valid_d;
   logic [CAP_W-1:0]   cap_next;
   logic               accept;
   logic               done_edge;

   assign accept    = ((state_q == S_IDLE) || (state_q == S_READY)) && bus.start;
   assign done_edge = (state_q == S_WAIT_DONE) && bus.doneloading;

   always_comb begin
      cap_sr_d   = cap_sr_q;
      ks_word_d  = ks_word_q;
      cap_cnt_d  = cap_cnt_q;
      cap_act_d  = cap_act_q;
      ks_valid_d = 1'b0;
      cap_next   = '0;

      if (accept) begin
         cap_act_d = 1'b0;
         cap_cnt_d = '0;
      end else if (done_edge || (cap_act_q && (state_q == S_READY))) begin
         cap_next = done_edge ? CAP_W'(1) : cap_cnt_q + 1'b1;
         cap_sr_d = {cap_sr_q[KS_BITS-2:0], bus.bitout};
         if (cap_next == CAP_FULL) begin
            ks_word_d  = cap_sr_d;
            ks_valid_d = 1'b1;
            cap_act_d  = 1'b0;
            cap_cnt_d  = '0;
         end else begin
            cap_act_d = 1'b1;
            cap_cnt_d = cap_next;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_sr_q   <= '0;
         ks_word_q  <= '0;
         cap_cnt_q  <= '0;
         cap_act_q  <= 1'b0;
         ks_valid_q <= 1'b0;
      end else begin
         cap_sr_q   <= cap_sr_d;
         ks_word_q  <= ks_word_d;
         cap_cnt_q  <= cap_cnt_d;
         cap_act_q  <= cap_act_d;
         ks_valid_q <= ks_valid_d;
      end
   end

   assign bus.ks_word  = ks_word_q;
   assign bus.ks_valid = ks_valid_q;
`else
   // Capture not built: the keystream bit has no consumer here.
   logic unused_bitout;
   assign unused_bitout = bus.bitout;
   assign bus.ks_word   = '0;
   assign bus.ks_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_a51_key_loader.sv
// ----------------------------------------------------------------------------
// tb_a51_key_loader
//   Self-checking bench for a51_key_loader. The keystream core is modelled in
//   the bench: it records the serial stream, answers doneloading after a
//   chosen delay and plays random keystream bits. Expected values come from
//   the load rules directly: the serial stream is {frame_in, key_in} sent LSB
//   first, and the captured word is the played bits packed first-bit-in-MSB.
// ----------------------------------------------------------------------------
module tb_a51_key_loader;

   localparam int KEY_BITS     = 64;
   localparam int FRAME_BITS   = 22;
   localparam int KS_BITS      = 32;
   localparam int DONE_TIMEOUT = 511;
   localparam int STREAM_BITS  = KEY_BITS + FRAME_BITS;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   a51_key_loader_if #(
      .KEY_BITS   (KEY_BITS),
      .FRAME_BITS (FRAME_BITS),
      .KS_BITS    (KS_BITS)
   ) bus ();

   a51_key_loader #(
      .KEY_BITS     (KEY_BITS),
      .FRAME_BITS   (FRAME_BITS),
      .KS_BITS      (KS_BITS),
      .DONE_TIMEOUT (DONE_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] all_outputs();
      return {bus.ks_valid, bus.ks_word, bus.err, bus.ready, bus.busy,
              bus.startloading, bus.keybit};
   endfunction

   // One complete load transaction.
   //   done_delay < 0 : core never answers, expect the timeout error
   //   poke           : re-pulse start with a different key during KEY
   //   spur_done      : pulse doneloading during KEY (must be ignored)
   //   abort_cap      : return early while the keystream capture is running
   task automatic do_load(input string tag, input logic [KEY_BITS-1:0] k,
                          input logic [FRAME_BITS-1:0] f, input int done_delay,
                          input bit poke, input bit spur_done, input bit abort_cap,
                          output logic [STREAM_BITS-1:0] obs);
      int                 sl_cnt;
      int                 kv_cnt;
      int                 idle_cnt;
      int                 elapsed;
      logic               b;
      logic [KS_BITS-1:0] exp_ks;

      @(negedge clk);
      bus.start    = 1'b1;
      bus.key_in   = k;
      bus.frame_in = f;
      @(negedge clk);
      bus.start = 1'b0;
      check({tag, ".start"},
            {bus.startloading, bus.keybit, bus.busy, bus.ready, bus.err, bus.ks_valid},
            6'b101000);

      sl_cnt   = 0;
      kv_cnt   = 0;
      idle_cnt = 0;
      for (int i = 0; i < STREAM_BITS; i++) begin
         if (poke && i == 10) begin
            bus.start    = 1'b1;
            bus.key_in   = ~k;
            bus.frame_in = ~f;
         end
         if (poke && i == 12) bus.start = 1'b0;
         if (spur_done) bus.doneloading = (i >= 20 && i < 24);
         @(negedge clk);
         obs[i] = bus.keybit;
         if (bus.startloading) sl_cnt++;
         if (bus.ks_valid) kv_cnt++;
         if (!bus.busy || bus.ready) idle_cnt++;
      end
      bus.start       = 1'b0;
      bus.doneloading = 1'b0;
      check({tag, ".stream"}, obs, {f, k});
      check({tag, ".quiet"}, {32'(sl_cnt), 32'(kv_cnt), 32'(idle_cnt)}, '0);

      // First cycle of WAIT_DONE: line idle, still busy.
      @(negedge clk);
      check({tag, ".wait"}, {bus.keybit, bus.busy, bus.ready}, 3'b010);

      if (done_delay < 0) begin
         elapsed = -1;
         for (int c = 2; c <= DONE_TIMEOUT + 40; c++) begin
            @(negedge clk);
            if (bus.err) begin
               elapsed = c - 1;
               break;
            end
         end
         check({tag, ".to_cycles"}, 128'(elapsed), 128'(DONE_TIMEOUT));
         check({tag, ".to_flags"}, {bus.err, bus.busy, bus.ready}, 3'b100);
         @(negedge clk);
         check({tag, ".to_pulse"}, {bus.err, bus.busy, bus.ready, bus.startloading}, 4'b0000);
         return;
      end

      repeat (done_delay) @(negedge clk);

      exp_ks = '0;
      kv_cnt = 0;
      for (int j = 0; j < KS_BITS; j++) begin
         if (j == 0) bus.doneloading = 1'b1;
         b          = 1'($urandom_range(1, 0));
         bus.bitout = b;
         exp_ks     = {exp_ks[KS_BITS-2:0], b};
         @(negedge clk);
         if (j == 0) begin
            bus.doneloading = 1'b0;
            check({tag, ".ready"}, {bus.err, bus.busy, bus.ready}, 3'b001);
         end
         if (abort_cap && j == 4) return;
         if (j < KS_BITS - 1 && bus.ks_valid) kv_cnt++;
      end
      check({tag, ".ks_early"}, 128'(kv_cnt), '0);
`ifdef A51_CAPTURE_EN
      check({tag, ".ks_word"}, {bus.ks_valid, bus.ks_word}, {1'b1, exp_ks});
      @(negedge clk);
      check({tag, ".ks_hold"}, {bus.ks_valid, bus.ks_word, bus.ready}, {1'b0, exp_ks, 1'b1});
`else
      check({tag, ".ks_word"}, {bus.ks_valid, bus.ks_word}, '0);
      @(negedge clk);
      check({tag, ".ks_hold"}, {bus.ks_valid, bus.ks_word, bus.ready}, {1'b0, 32'h0, 1'b1});
`endif
   endtask

   initial begin
      logic [STREAM_BITS-1:0] obs;
      int                     sl_cnt;
      int                     busy_cnt;

      bus.start       = 1'b0;
      bus.key_in      = '0;
      bus.frame_in    = '0;
      bus.doneloading = 1'b0;
      bus.bitout      = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset.outputs", all_outputs(), '0);
      rst = 1'b0;
      @(negedge clk);
      check("reset.idle", all_outputs(), '0);

      // Directed bit order
      do_load("order", 64'hEFCDAB8967452312, 22'h134, 3, 1'b0, 1'b0, 1'b0, obs);
      check("order.byte0", obs[7:0], 8'h12);
      check("order.frame", obs[STREAM_BITS-1:KEY_BITS], 22'h134);

      // Reload straight from READY with an all-zero key
      do_load("reload", '0, 22'($urandom), 0, 1'b0, 1'b0, 1'b0, obs);

      // start during KEY is ignored
      do_load("poke", {$urandom, $urandom}, 22'($urandom), 5, 1'b1, 1'b0, 1'b0, obs);

      // doneloading before WAIT_DONE is ignored
      do_load("spur", {$urandom, $urandom}, 22'($urandom), 2, 1'b0, 1'b1, 1'b0, obs);

      // Capture aborted by a new start, then a clean load
      do_load("abort", {$urandom, $urandom}, 22'($urandom), 1, 1'b0, 1'b0, 1'b1, obs);
      do_load("after_abort", {$urandom, $urandom}, 22'($urandom), 4, 1'b0, 1'b0, 1'b0, obs);

      // Random loads
      for (int n = 0; n < 4; n++)
         do_load($sformatf("rand%0d", n), {$urandom, $urandom}, 22'($urandom),
                 int'($urandom_range(20, 0)), 1'b0, 1'b0, 1'b0, obs);

      // Timeout, then a load from IDLE
      do_load("timeout", {$urandom, $urandom}, 22'($urandom), -1, 1'b0, 1'b0, 1'b0, obs);
      do_load("post_to", {$urandom, $urandom}, 22'($urandom), 7, 1'b0, 1'b0, 1'b0, obs);

      // Asynchronous reset in the middle of KEY
      @(negedge clk);
      bus.start    = 1'b1;
      bus.key_in   = '1;
      bus.frame_in = '0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_mid.pre", {bus.busy, bus.keybit}, 2'b11);
      #2 rst = 1'b1;
      #1 check("rst_mid.async", all_outputs(), '0);
      @(negedge clk);
      rst      = 1'b0;
      sl_cnt   = 0;
      busy_cnt = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.startloading) sl_cnt++;
         if (bus.busy || bus.keybit || bus.ready) busy_cnt++;
      end
      check("rst_mid.idle", {32'(sl_cnt), 32'(busy_cnt)}, '0);

      do_load("post_rst", {$urandom, $urandom}, 22'($urandom), 2, 1'b0, 1'b0, 1'b0, obs);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always ends on its own.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $finish;
   end

endmodule
